// File: rtl/regfile_mp.sv
// Multi-port register file: 2 combinational read ports, 2 write ports, sweep-clear after reset.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] D1,
    output logic [XLEN-1:0] D2,
    input  logic            WE3,
    input  logic            WE4,
    input  logic [AW-1:0]   A3,
    input  logic [AW-1:0]   A4,
    input  logic [XLEN-1:0] D3,
    input  logic [XLEN-1:0] D4,
    output logic            ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];

    logic wr3_c;
    logic wr4_c;
    logic rd_en_c;

    assign wr3_c   = WE3 && (A3 != '0);
    assign wr4_c   = WE4 && (A4 != '0);
    assign rd_en_c = (state == RUN) && !rst;

    // Sweep-clear FSM and array updates; port 3 is applied last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[cnt] <= '0;
                    cnt       <= cnt + AW'(1);
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr4_c) regs[A4] <= D4;
                    if (wr3_c) regs[A3] <= D3;
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Read port 1: zero outside RUN and for address 0.
    always_comb begin
        D1 = '0;
        if (rd_en_c && (A1 != '0)) begin
            D1 = regs[A1];
`ifdef REGFILE_BYPASS_EN
            if (wr4_c && (A4 == A1)) D1 = D4;
            if (wr3_c && (A3 == A1)) D1 = D3;
`endif
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        D2 = '0;
        if (rd_en_c && (A2 != '0)) begin
            D2 = regs[A2];
`ifdef REGFILE_BYPASS_EN
            if (wr4_c && (A4 == A2)) D2 = D4;
            if (wr3_c && (A3 == A2)) D2 = D3;
`endif
        end
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of each register.
REQ-002 SHALL have parameter NREGS, default 32: register count; power of two, 2..64.
REQ-003 SHALL derive AW = $clog2(NREGS) as a localparam; it SHALL NOT be overridable.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-006 SHALL have ports A1, A2  input  AW: read addresses, ports 1 and 2.
REQ-007 SHALL have ports D1, D2  output  XLEN: combinational read data, ports 1 and 2.
REQ-008 SHALL have ports WE3, WE4  input  1: write enables, write ports 3 and 4.
REQ-009 SHALL have ports A3, A4  input  AW: write addresses.
REQ-010 SHALL have ports D3, D4  input  XLEN: write data.
REQ-011 SHALL have port ready  output  1: high when the array is initialised and accepts writes.

Function
REQ-012 SHALL implement a two-state FSM, CLEAR and RUN; ready = 1 only in RUN.
REQ-013 CLEAR: each posedge with rst low SHALL write 0 to regs[cnt] and increment an AW-bit counter cnt.
REQ-014 CLEAR SHALL move to RUN on the posedge that clears regs[NREGS-1]; ready SHALL rise exactly NREGS cycles after rst falls.
REQ-015 In CLEAR, WE3 and WE4 SHALL be ignored and D1 and D2 SHALL read 0.
REQ-016 RUN: on posedge, if WEn=1 and An!=0, regs[An] SHALL take Dn (n = 3, 4).
REQ-017 Writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0 at all times.
REQ-018 If WE3=WE4=1 and A3=A4!=0 in the same cycle, D3 SHALL win; D4 SHALL be dropped.
REQ-019 Different write addresses in the same cycle SHALL both commit.
REQ-020 Reads SHALL be combinational from array contents; a write SHALL be visible from the cycle after its posedge (unless REQ-026 applies).
REQ-021 Read ports SHALL be independent; A1=A2 SHALL return identical data.
REQ-022 There SHALL be no X on D1 or D2 after ready rises.

Reset
REQ-023 rst=1 at a posedge SHALL set state=CLEAR and cnt=0; ready SHALL be 0 from that edge.
REQ-024 rst asserted mid-CLEAR SHALL restart the sweep at cnt=0; rst asserted in RUN SHALL discard any write in that cycle and restart the sweep.
REQ-025 While rst is held, the array SHALL be unmodified; D1 and D2 SHALL read 0.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined: in RUN, if Ax (x = 1, 2) matches a valid write address in the same cycle (WEn=1, An!=0), Dx SHALL return that write data combinationally; REQ-018 priority applies (D3 over D4).
REQ-027 Without REGFILE_BYPASS_EN: there SHALL be no bypass; same-cycle reads SHALL return old contents, and the bypass logic SHALL be fully absent.

Verification
REQ-028 rst 1 cycle, then low -> ready=0 for exactly 32 cycles, ready=1 on cycle 32; all 32 registers read 0.
REQ-029 RUN: WE3=1, A3=5, D3=0xDEADBEEF; next cycle A1=5 -> D1=0xDEADBEEF; WE4=1, A4=0, D4=0x1234, then A2=0 -> D2=0.
REQ-030 WE3=WE4=1, A3=A4=7, D3=0x11, D4=0x22 -> next cycle reg 7 reads 0x11; A3=3, A4=9 in one cycle -> both committed.
REQ-031 Bypass build: WE4=1, A4=10, D4=0xCAFE, A1=10 in the same cycle -> D1=0xCAFE combinationally; non-bypass build -> D1=old value.
REQ-032 rst pulsed at sweep cycle 12 -> ready stays 0; rises 32 cycles after the second rst release; a write in CLEAR to reg 4 -> reg 4 reads 0 after ready.
REQ-033 Parameter sweep XLEN=64, NREGS=16 -> ready after 16 cycles; 64-bit value 0xFFFF_0000_FFFF_0000 round-trips through reg 15.
